// File: rtl/fifo_loop_ctrl_pkg.sv
// Shared types and default timing constants for the FIFO loop test sequencer.
package fifo_loop_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned TICK_HZ       = 1000;
    localparam int unsigned TICK_MAX_DFLT = CLK_HZ / TICK_HZ / 2;
    localparam int unsigned ROUND_CNT_W   = 16;

endpackage

// File: rtl/fifo_loop_tick.sv
// Clock-enable generator: one-cycle tick every TICK_MAX cycles while enabled.
module fifo_loop_tick #(
    parameter int unsigned TICK_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_c = en && (cnt_q == CNT_W'(TICK_MAX - 1));
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_loop_ctrl.sv
// FIFO demo sequencer: fills with an incrementing pattern on ticks, drains and
// checks every word, counting rounds and flagging any mismatch.
module fifo_loop_ctrl
    import fifo_loop_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned TICK_MAX = TICK_MAX_DFLT,
    parameter int unsigned SETTLE   = 4
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   continuous,
    output logic                   wr_req,
    output logic [DATA_W-1:0]      wr_data,
    input  logic                   wr_full,
    output logic                   rd_req,
    input  logic [DATA_W-1:0]      rd_data,
    input  logic                   rd_empty,
    output logic                   busy,
    output logic                   round_done,
    output logic                   err,
    output logic [ROUND_CNT_W-1:0] round_cnt
);

    localparam int unsigned CNT_MAX = (DEPTH > SETTLE) ? DEPTH : SETTLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0]        pattern_q, pattern_d;
    logic [DATA_W-1:0]        expect_q, expect_d;
    logic [DATA_W-1:0]        wr_data_q, wr_data_d;
    logic [ROUND_CNT_W-1:0]   round_cnt_q, round_cnt_d;
    logic                     wr_req_q, wr_req_d;
    logic                     rd_req_q, rd_req_d;
    logic                     rd_vld_q, rd_vld_d;
    logic                     busy_q, busy_d;
    logic                     round_done_q, round_done_d;
    logic                     err_q, err_d;
    logic                     tick_c;
    logic                     tick_clr_c;
    logic                     drain_end_c;

    fifo_loop_tick #(
        .TICK_MAX (TICK_MAX)
    ) u_tick (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .en     (state_q != ST_IDLE),
        .clr    (tick_clr_c),
        .tick_c (tick_c)
    );

    // Drain ends once all written words (or an empty FIFO) are consumed and no read is in flight.
    assign drain_end_c = ((word_cnt_q == fill_cnt_q) || (tick_c && rd_empty))
                         && !rd_req_q && !rd_vld_q;
    assign tick_clr_c  = (state_d != state_q);

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        fill_cnt_d   = fill_cnt_q;
        pattern_d    = pattern_q;
        expect_d     = expect_q;
        wr_data_d    = wr_data_q;
        round_cnt_d  = round_cnt_q;
        err_d        = err_q;
        wr_req_d     = 1'b0;
        rd_req_d     = 1'b0;
        round_done_d = 1'b0;
        rd_vld_d     = rd_req_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FILL;
                    err_d       = 1'b0;
                    round_cnt_d = '0;
                    pattern_d   = '0;
                    expect_d    = '0;
                    word_cnt_d  = '0;
                end
            end
            ST_FILL: begin
                if ((word_cnt_q == CNT_W'(DEPTH)) || wr_full) begin
                    state_d    = ST_SETTLE;
                    fill_cnt_d = word_cnt_q;
                    word_cnt_d = '0;
                end else if (tick_c) begin
                    wr_req_d   = 1'b1;
                    wr_data_d  = pattern_q;
                    pattern_d  = pattern_q + DATA_W'(1);
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (word_cnt_q >= CNT_W'(SETTLE - 1)) begin
                    state_d    = ST_DRAIN;
                    word_cnt_d = '0;
                end else begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (rd_vld_q) begin
                    if (rd_data != expect_q) begin
                        err_d = 1'b1;
                    end
                    expect_d = expect_q + DATA_W'(1);
                end
                if (drain_end_c) begin
                    round_done_d = 1'b1;
                    round_cnt_d  = round_cnt_q + ROUND_CNT_W'(1);
                    word_cnt_d   = '0;
                    state_d      = (stop || !continuous) ? ST_IDLE : ST_FILL;
                end else if (tick_c && !rd_empty && (word_cnt_q < fill_cnt_q)) begin
                    rd_req_d   = 1'b1;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            fill_cnt_q   <= '0;
            pattern_q    <= '0;
            expect_q     <= '0;
            wr_data_q    <= '0;
            round_cnt_q  <= '0;
            err_q        <= 1'b0;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_vld_q     <= 1'b0;
            busy_q       <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            fill_cnt_q   <= fill_cnt_d;
            pattern_q    <= pattern_d;
            expect_q     <= expect_d;
            wr_data_q    <= wr_data_d;
            round_cnt_q  <= round_cnt_d;
            err_q        <= err_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
            rd_vld_q     <= rd_vld_d;
            busy_q       <= busy_d;
            round_done_q <= round_done_d;
        end
    end

    assign wr_req     = wr_req_q;
    assign wr_data    = wr_data_q;
    assign rd_req     = rd_req_q;
    assign busy       = busy_q;
    assign round_done = round_done_q;
    assign err        = err_q;
    assign round_cnt  = round_cnt_q;

endmodule

// File: tb/tb_fifo_loop_ctrl.sv
// Bench for fifo_loop_ctrl: two instances (8-bit/DEPTH 8 and 4-bit/DEPTH 12)
// each paired with a behavioural non-show-ahead FIFO.
module tb_fifo_loop_ctrl;

    localparam int unsigned A_DW    = 8;
    localparam int unsigned A_DEPTH = 8;
    localparam int unsigned A_TICK  = 4;
    localparam int unsigned B_DW    = 4;
    localparam int unsigned B_DEPTH = 12;
    localparam int unsigned B_TICK  = 2;
    localparam int          RND_TO  = 500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A ----------------
    logic            a_start = 1'b0, a_stop = 1'b0, a_cont = 1'b0;
    logic            a_wr_req, a_rd_req, a_full, a_empty, a_busy, a_round_done, a_err;
    logic [A_DW-1:0] a_wr_data;
    logic [A_DW-1:0] a_rd_data = '0;
    logic [15:0]     a_round_cnt;

    fifo_loop_ctrl #(.DATA_W(A_DW), .DEPTH(A_DEPTH), .TICK_MAX(A_TICK), .SETTLE(4)) u_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(a_start), .stop(a_stop), .continuous(a_cont),
        .wr_req(a_wr_req), .wr_data(a_wr_data), .wr_full(a_full),
        .rd_req(a_rd_req), .rd_data(a_rd_data), .rd_empty(a_empty),
        .busy(a_busy), .round_done(a_round_done), .err(a_err), .round_cnt(a_round_cnt)
    );

    logic [A_DW-1:0] a_mem [32];
    int   a_wp = 0, a_rp = 0, a_rdn = 0;
    int   a_cap = 32, a_corrupt = -1;
    logic a_clr = 1'b0;

    assign a_full  = (a_wp - a_rp) >= a_cap;
    assign a_empty = (a_wp == a_rp);

    always @(posedge clk) begin
        if (a_clr) begin
            a_wp <= 0; a_rp <= 0; a_rdn <= 0;
        end else begin
            if (a_wr_req && (a_wp - a_rp) < a_cap) begin
                a_mem[a_wp % 32] <= a_wr_data;
                a_wp <= a_wp + 1;
            end
            if (a_rd_req && a_wp != a_rp) begin
                a_rd_data <= (a_rdn == a_corrupt) ? '1 : a_mem[a_rp % 32];
                a_rp  <= a_rp + 1;
                a_rdn <= a_rdn + 1;
            end
        end
    end

    logic [A_DW-1:0] a_log [256];
    int   a_log_c [256];
    int   a_nw = 0, a_nr = 0, a_nrd = 0, overlap = 0;

    always @(negedge clk) begin
        if (a_wr_req) begin
            if (a_nw < 256) begin
                a_log[a_nw]   <= a_wr_data;
                a_log_c[a_nw] <= cyc;
            end
            a_nw <= a_nw + 1;
        end
        if (a_rd_req)               a_nr  <= a_nr + 1;
        if (a_round_done)           a_nrd <= a_nrd + 1;
        if (a_wr_req && a_rd_req)   overlap <= overlap + 1;
    end

    // ---------------- instance B ----------------
    logic            b_start = 1'b0, b_stop = 1'b0, b_cont = 1'b0;
    logic            b_wr_req, b_rd_req, b_full, b_empty, b_busy, b_round_done, b_err;
    logic [B_DW-1:0] b_wr_data;
    logic [B_DW-1:0] b_rd_data = '0;
    logic [15:0]     b_round_cnt;

    fifo_loop_ctrl #(.DATA_W(B_DW), .DEPTH(B_DEPTH), .TICK_MAX(B_TICK), .SETTLE(4)) u_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(b_start), .stop(b_stop), .continuous(b_cont),
        .wr_req(b_wr_req), .wr_data(b_wr_data), .wr_full(b_full),
        .rd_req(b_rd_req), .rd_data(b_rd_data), .rd_empty(b_empty),
        .busy(b_busy), .round_done(b_round_done), .err(b_err), .round_cnt(b_round_cnt)
    );

    logic [B_DW-1:0] b_mem [32];
    int   b_wp = 0, b_rp = 0;
    logic b_clr = 1'b0;

    assign b_full  = (b_wp - b_rp) >= 16;
    assign b_empty = (b_wp == b_rp);

    always @(posedge clk) begin
        if (b_clr) begin
            b_wp <= 0; b_rp <= 0;
        end else begin
            if (b_wr_req && (b_wp - b_rp) < 16) begin
                b_mem[b_wp % 32] <= b_wr_data;
                b_wp <= b_wp + 1;
            end
            if (b_rd_req && b_wp != b_rp) begin
                b_rd_data <= b_mem[b_rp % 32];
                b_rp <= b_rp + 1;
            end
        end
    end

    logic [B_DW-1:0] b_log [64];
    int   b_nw = 0, b_nrd = 0;

    always @(negedge clk) begin
        if (b_wr_req) begin
            if (b_nw < 64) b_log[b_nw] <= b_wr_data;
            b_nw <= b_nw + 1;
        end
        if (b_round_done)         b_nrd <= b_nrd + 1;
        if (b_wr_req && b_rd_req) overlap <= overlap + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic a_clear_fifo();
        @(negedge clk); a_clr = 1'b1;
        @(negedge clk); a_clr = 1'b0;
    endtask

    task automatic a_kick();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic a_wait_idle(output int ok);
        ok = 0;
        for (int i = 0; i < 4 * RND_TO; i++) begin
            if (!a_busy) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic a_wait_rc(input int k, output int ok);
        ok = 0;
        for (int i = 0; i < 4 * RND_TO; i++) begin
            if (a_round_cnt == 16'(k)) begin ok = 1; break; end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int cap;
        int corrupt;
        int exp_wr;
        int exp_rd;
        int exp_err;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int ok;
        int base_w, base_r, base_d, nbad;

        vecs[0] = '{32, -1, 8, 8, 0};
        vecs[1] = '{5,  -1, 5, 5, 0};
        vecs[2] = '{32,  2, 8, 8, 1};

        a_clr = 1'b1; b_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",       a_busy, 0);
        chk("rst_wr_req",     a_wr_req, 0);
        chk("rst_rd_req",     a_rd_req, 0);
        chk("rst_wr_data",    a_wr_data, 0);
        chk("rst_round_done", a_round_done, 0);
        chk("rst_err",        a_err, 0);
        chk("rst_round_cnt",  a_round_cnt, 0);
        rst_n = 1'b1; a_clr = 1'b0; b_clr = 1'b0;
        repeat (2) @(negedge clk);

        // Single-round vectors against the FIFO model
        for (int v = 0; v < 3; v++) begin
            a_cap = vecs[v].cap; a_corrupt = vecs[v].corrupt; a_cont = 1'b0;
            a_clear_fifo();
            base_w = a_nw; base_r = a_nr; base_d = a_nrd;
            a_kick();
            chk($sformatf("v%0d_busy_up", v), a_busy, 1);
            a_wait_idle(ok);
            chk($sformatf("v%0d_done_in_time", v), ok, 1);
            chk($sformatf("v%0d_writes", v), a_nw - base_w, vecs[v].exp_wr);
            chk($sformatf("v%0d_reads", v), a_nr - base_r, vecs[v].exp_rd);
            chk($sformatf("v%0d_round_done", v), a_nrd - base_d, 1);
            chk($sformatf("v%0d_round_cnt", v), a_round_cnt, 1);
            chk($sformatf("v%0d_err", v), a_err, vecs[v].exp_err);
            nbad = 0;
            for (int i = 0; i < vecs[v].exp_wr; i++) begin
                if (a_log[base_w + i] != A_DW'(i)) nbad++;
                if (i > 0 && (a_log_c[base_w + i] - a_log_c[base_w + i - 1]) != A_TICK) nbad++;
            end
            chk($sformatf("v%0d_wr_data_spacing_bad", v), nbad, 0);
        end

        // Sticky error across a second round, then cleared by a fresh start
        a_cap = 32; a_corrupt = 2; a_cont = 1'b1;
        a_clear_fifo();
        a_kick();
        a_wait_rc(1, ok);
        chk("sticky_rc1_reached", ok, 1);
        chk("sticky_err_round1", a_err, 1);
        a_stop = 1'b1;
        a_wait_idle(ok);
        chk("sticky_idle", ok, 1);
        chk("sticky_round_cnt", a_round_cnt, 2);
        chk("sticky_err_round2", a_err, 1);
        a_stop = 1'b0; a_cont = 1'b0; a_corrupt = -1;
        a_clear_fifo();
        a_kick();
        chk("restart_err_clear", a_err, 0);
        chk("restart_rc_clear", a_round_cnt, 0);
        a_wait_idle(ok);
        chk("restart_err_end", a_err, 0);
        chk("restart_rc_end", a_round_cnt, 1);

        // Continuous rounds, stop raised during the third fill
        a_cont = 1'b1;
        a_clear_fifo();
        base_w = a_nw; base_d = a_nrd;
        a_kick();
        a_wait_rc(2, ok);
        chk("cont_rc2_reached", ok, 1);
        a_stop = 1'b1;
        a_wait_idle(ok);
        chk("cont_idle", ok, 1);
        chk("cont_round_cnt", a_round_cnt, 3);
        chk("cont_round_done", a_nrd - base_d, 3);
        chk("cont_writes", a_nw - base_w, 24);
        chk("cont_round2_first", a_log[base_w + 8], 8);
        chk("cont_err", a_err, 0);
        chk("cont_fifo_empty", a_empty, 1);
        nbad = 0;
        for (int i = 0; i < 24; i++) if (a_log[base_w + i] != A_DW'(i)) nbad++;
        chk("cont_data_bad", nbad, 0);
        a_stop = 1'b0;

        // Async reset in the middle of the second round's drain
        a_corrupt = 2;
        a_clear_fifo();
        base_r = a_nr;
        a_kick();
        ok = 0;
        for (int i = 0; i < 4 * RND_TO; i++) begin
            if (a_nr > base_r + 9) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("rst_mid_drain_reached", ok, 1);
        chk("pre_rst_busy", a_busy, 1);
        chk("pre_rst_err", a_err, 1);
        chk("pre_rst_round_cnt", a_round_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", a_busy, 0);
        chk("async_err", a_err, 0);
        chk("async_round_cnt", a_round_cnt, 0);
        chk("async_wr_data", a_wr_data, 0);
        chk("async_rd_req", a_rd_req, 0);
        chk("async_wr_req", a_wr_req, 0);
        @(negedge clk);
        rst_n = 1'b1; a_cont = 1'b0; a_corrupt = -1;
        a_clear_fifo();
        base_w = a_nw;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", a_busy, 0);
        chk("post_rst_no_writes", a_nw - base_w, 0);

        // Narrow data path wraps 15 -> 0 over two continuous rounds
        b_cont = 1'b1;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        ok = 0;
        for (int i = 0; i < 4 * RND_TO; i++) begin
            if (b_round_cnt == 16'd1) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("b_rc1_reached", ok, 1);
        b_stop = 1'b1;
        ok = 0;
        for (int i = 0; i < 4 * RND_TO; i++) begin
            if (!b_busy) begin ok = 1; break; end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("b_idle", ok, 1);
        chk("b_round_cnt", b_round_cnt, 2);
        chk("b_round_done", b_nrd, 2);
        chk("b_err", b_err, 0);
        chk("b_writes", b_nw, 24);
        chk("b_wrap_15", b_log[15], 15);
        chk("b_wrap_0", b_log[16], 0);
        nbad = 0;
        for (int i = 0; i < 24; i++) if (b_log[i] != B_DW'(i)) nbad++;
        chk("b_data_bad", nbad, 0);
        b_stop = 1'b0; b_cont = 1'b0;

        chk("wr_rd_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
